// File: rtl/i2s_tx_multi.sv
// Multi-line I2S / left-justified transmitter with a one-deep holding buffer.
// sclk comes from a prescaled system clock; data changes on sclk falling transitions.
module i2s_tx_multi #(
   parameter int DATA_W = 16,
   parameter int NLINES = 1,
   parameter int PRE_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     mode,
   input  logic [PRE_W-1:0]         prescaler,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NLINES*DATA_W-1:0] left_chan,
   input  logic [NLINES*DATA_W-1:0] right_chan,
   output logic                     sclk,
   output logic                     lrclk,
   output logic [NLINES-1:0]        sdata,
   output logic                     frame_start,
   output logic                     underrun
);

   localparam int FW = 2 * DATA_W;
   localparam int BW = $clog2(FW);

   // ST_PRIME: first sclk period after enable/reset, ends with a frame load at b=0
   typedef enum logic {ST_PRIME, ST_RUN} state_t;

   state_t                    state, state_n;
   logic [PRE_W-1:0]          pcnt, pre_l, pre_eff;
   logic [BW-1:0]             b, b_n;
   logic                      tc, fall, load, cap, full;
   logic                      mode_l, mode_n, lr_n;
   logic [NLINES*DATA_W-1:0]  buf_l, buf_r;
   logic [FW-2:0]             sh      [NLINES];
   logic [FW-1:0]             ld_word [NLINES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_PRIME;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      // each half period uses the prescaler value seen at its start
      pre_eff = (pcnt == '0) ? prescaler : pre_l;
      tc      = (pcnt == pre_eff);
      fall    = enable && tc && sclk;
      load    = fall && ((state == ST_PRIME) || (b == BW'(FW - 1)));
      b_n     = load ? '0 : b + BW'(1);
      mode_n  = load ? mode : mode_l;
      if (mode_n) lr_n = (b_n >= BW'(DATA_W));
      else        lr_n = (b_n != BW'(FW - 1)) && ((b_n + BW'(1)) >= BW'(DATA_W));
      if (!enable)   state_n = ST_PRIME;
      else if (load) state_n = ST_RUN;
      cap = in_valid && in_ready;
      for (int unsigned k = 0; k < NLINES; k++)
         ld_word[k] = full ? {buf_l[k*DATA_W +: DATA_W], buf_r[k*DATA_W +: DATA_W]} : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt        <= '0;
         pre_l       <= '0;
         sclk        <= 1'b0;
         b           <= '0;
         lrclk       <= 1'b0;
         sdata       <= '0;
         mode_l      <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         in_ready    <= 1'b1;
         full        <= 1'b0;
         buf_l       <= '0;
         buf_r       <= '0;
         for (int unsigned k = 0; k < NLINES; k++) sh[k] <= '0;
      end else begin
         frame_start <= load;
         underrun    <= load && !full;
         // in_ready trails the buffer emptying by one clk, so it rises after frame_start
         in_ready    <= !cap && !full;
         pre_l       <= pre_eff;
         if (load) full <= 1'b0;
         if (cap) begin
            full  <= 1'b1;
            buf_l <= left_chan;
            buf_r <= right_chan;
         end
         if (!enable) begin
            pcnt  <= '0;
            sclk  <= 1'b0;
            b     <= '0;
            lrclk <= 1'b0;
            sdata <= '0;
            for (int unsigned k = 0; k < NLINES; k++) sh[k] <= '0;
         end else begin
            if (tc) begin
               pcnt <= '0;
               sclk <= !sclk;
            end else begin
               pcnt <= pcnt + PRE_W'(1);
            end
            if (fall) begin
               b      <= b_n;
               lrclk  <= lr_n;
               mode_l <= mode_n;
               for (int unsigned k = 0; k < NLINES; k++) begin
                  if (load) begin
                     sdata[k] <= ld_word[k][FW-1];
                     sh[k]    <= ld_word[k][FW-2:0];
                  end else begin
                     sdata[k] <= sh[k][FW-2];
                     sh[k]    <= {sh[k][FW-3:0], 1'b0};
                  end
               end
            end
         end
      end
   end

endmodule
